imem_boot_loader: RTL and testbench

// - Parametrised instruction memory with built-in boot loader, successor to the fixed 1000-word fetch ROM.
// - Clears its array after reset, loads a program over a valid/ready word stream, then serves core fetches.
// - Fetches take a byte-address PC and return the instruction one cycle later, with a valid flag.
// - Flags misaligned and out-of-range fetches instead of indexing garbage.
// - Sits between the boot source (testbench/UART/DMA) and the IF stage of the RISC-V core.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_sram_1p.sv | 37 +++
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : imem_pkg                                                         |
// | Shared types and helpers for the boot-loading instruction memory.          |
// |   im_state_t : CLEAR (array wipe) -> LOAD (word stream) -> RUN (fetch)     |
// |   NOP        : addi x0,x0,0, used as clear value and bad-fetch return      |
// |   word_oob() : range check on a byte offset already rebased to word 0      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package imem_pkg;

   typedef enum logic [1:0] {
      IM_CLEAR = 2'd0,
      IM_LOAD  = 2'd1,
      IM_RUN   = 2'd2
   } im_state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // The offset is PC - BASE_ADDR computed with unsigned wrap-around, so a PC
   // below the base shows up as a huge offset and fails this test as well.
   // Widened to 64 bits so the span 4*DEPTH never overflows.
   function automatic logic word_oob(input logic [63:0] offset,
                                     input logic [63:0] span);
      return (offset >= span);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_sram_1p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_sram_1p                                                     |
// | Single-port synchronous RAM, DEPTH x XLEN. Drop-in point for a macro.      |
// | Ports   : clk   - clock                                                    |
// |           we    - write enable, writes wdata to addr                       |
// |           re    - read enable, rdata <= mem[addr] next edge                |
// |           addr  - word address                                             |
// |           wdata - write data                                               |
// |           rdata - registered read data, holds when re=0                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module imem_sram_1p #(
   parameter int DEPTH = 1024,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XLEN-1:0]          wdata,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_boot_loader                                                 |
// | Instruction memory that clears itself after reset, accepts a program over  |
// | a valid/ready word stream, then serves IF-stage fetches with one cycle of  |
// | latency and flags misaligned / out-of-range PCs.                           |
// | Ports   : SYS_clk, SYS_reset_n (async, active-low)                         |
// |           load_start           - RUN only: restart loading at word 0       |
// |           ld_valid/ld_data/ld_last/ld_ready - loader stream                |
// |           load_done            - high while in RUN                         |
// |           load_overflow        - sticky, word offered to a full array      |
// |           load_count           - words written by current/last load        |
// |           fetch_req, PC        - fetch request with byte address           |
// |           instruction, instr_valid, fetch_misaligned, fetch_oob - result   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int              DEPTH     = 1024,
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = '0,
   parameter logic [XLEN-1:0] FILL_WORD = NOP
) (
   input  logic                     SYS_clk,
   input  logic                     SYS_reset_n,
   input  logic                     load_start,
   input  logic                     ld_valid,
   input  logic [XLEN-1:0]          ld_data,
   input  logic                     ld_last,
   output logic                     ld_ready,
   output logic                     load_done,
   output logic                     load_overflow,
   output logic [$clog2(DEPTH):0]   load_count,
   input  logic                     fetch_req,
   input  logic [XLEN-1:0]          PC,
   output logic [XLEN-1:0]          instruction,
   output logic                     instr_valid,
   output logic                     fetch_misaligned,
   output logic                     fetch_oob
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   im_state_t        state, state_next;
   logic [AW-1:0]    clr_ptr;
   logic             fill_sel;      // last accepted fetch was bad (or none yet)

   logic             xfer;
   logic             full;
   logic             fetch_go;
   logic             misaligned;
   logic             oob;
   logic [XLEN-1:0]  offset;
   logic             ram_we;
   logic             ram_re;
   logic [AW-1:0]    ram_addr;
   logic [XLEN-1:0]  ram_wdata;
   logic [XLEN-1:0]  ram_rdata;

   assign ld_ready   = (state == IM_LOAD);
   assign load_done  = (state == IM_RUN);
   assign xfer       = ld_valid && ld_ready;
   assign full       = (load_count == CW'(DEPTH));
   // A simultaneous load_start discards the fetch.
   assign fetch_go   = (state == IM_RUN) && fetch_req && !load_start;

   assign offset     = PC - BASE_ADDR;
   assign misaligned = |PC[1:0];
   assign oob        = word_oob(64'(offset), 64'(DEPTH) * 64'd4);

   // Exactly one port user per state: clear writer, loader writer, fetch reader.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = offset[AW+1:2];
      ram_wdata = ld_data;
      unique case (state)
         IM_CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = clr_ptr;
            ram_wdata = FILL_WORD;
         end
         IM_LOAD: begin
            ram_we   = xfer && !full;
            ram_addr = load_count[AW-1:0];
         end
         default: ;
      endcase
   end

   assign ram_re = fetch_go && !misaligned && !oob;

   imem_sram_1p #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_sram (
      .clk   (SYS_clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // RAM output has no reset and holds between reads, so the fill mux makes
   // the reset value and bad-fetch value FILL_WORD without touching the array.
   assign instruction = fill_sel ? FILL_WORD : ram_rdata;

   always_comb begin
      state_next = state;
      unique case (state)
         IM_CLEAR: if (clr_ptr == AW'(DEPTH - 1)) state_next = IM_LOAD;
         IM_LOAD:  if (xfer && ld_last)           state_next = IM_RUN;
         IM_RUN:   if (load_start)                state_next = IM_LOAD;
         default:                                 state_next = IM_CLEAR;
      endcase
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         state            <= IM_CLEAR;
         clr_ptr          <= '0;
         load_count       <= '0;
         load_overflow    <= 1'b0;
         instr_valid      <= 1'b0;
         fetch_misaligned <= 1'b0;
         fetch_oob        <= 1'b0;
         fill_sel         <= 1'b1;
      end else begin
         state <= state_next;

         if (state == IM_CLEAR) begin
            clr_ptr <= clr_ptr + AW'(1);   // wraps to 0 on the last write
         end

         if ((state == IM_RUN) && load_start) begin
            load_count <= '0;
         end else if (xfer && !full) begin
            load_count <= load_count + CW'(1);
         end

         if (xfer && full) begin
            load_overflow <= 1'b1;
         end

         instr_valid <= fetch_go;
         if (fetch_go) begin
            fetch_misaligned <= misaligned;
            fetch_oob        <= oob;
            fill_sel         <= misaligned || oob;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_imem_boot_loader                                              |
// | Directed bench for imem_boot_loader: clear, load, fetch table, reload,     |
// | overflow and asynchronous reset mid-load.                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_imem_boot_loader;

   localparam int          DEPTH = 64;
   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start, ld_valid, ld_last, ld_ready;
   logic [31:0]   ld_data;
   logic          load_done, load_overflow;
   logic [CW-1:0] load_count;
   logic          fetch_req;
   logic [31:0]   PC;
   logic [31:0]   instruction;
   logic          instr_valid, fetch_misaligned, fetch_oob;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .DEPTH     (DEPTH),
      .XLEN      (32),
      .BASE_ADDR (32'h0000_0000),
      .FILL_WORD (32'h0000_0013)
   ) dut (
      .SYS_clk          (clk),
      .SYS_reset_n      (rst_n),
      .load_start       (load_start),
      .ld_valid         (ld_valid),
      .ld_data          (ld_data),
      .ld_last          (ld_last),
      .ld_ready         (ld_ready),
      .load_done        (load_done),
      .load_overflow    (load_overflow),
      .load_count       (load_count),
      .fetch_req        (fetch_req),
      .PC               (PC),
      .instruction      (instruction),
      .instr_valid      (instr_valid),
      .fetch_misaligned (fetch_misaligned),
      .fetch_oob        (fetch_oob)
   );

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic        ev;
      logic [31:0] ei;
      logic        em;
      logic        eo;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, " ld_ready"}, ld_ready, 1'b0);
      chk1({tag, " load_done"}, load_done, 1'b0);
      chk1({tag, " load_overflow"}, load_overflow, 1'b0);
      chk32({tag, " load_count"}, 32'(load_count), 32'd0);
      chk1({tag, " instr_valid"}, instr_valid, 1'b0);
      chk1({tag, " misaligned"}, fetch_misaligned, 1'b0);
      chk1({tag, " oob"}, fetch_oob, 1'b0);
      chk32({tag, " instruction"}, instruction, NOPW);
   endtask

   // Counts cycles from reset release to ld_ready; a fetch is held high the
   // whole time and must never produce instr_valid.
   task automatic wait_clear(input string tag);
      int n = 0;
      int stray = 0;
      fetch_req = 1'b1;
      PC        = 32'h0;
      while (!ld_ready && n < DEPTH + 8) begin
         tick();
         n++;
         if (instr_valid) stray++;
      end
      fetch_req = 1'b0;
      chk32({tag, " clear cycles"}, 32'(n), 32'(DEPTH));
      chk32({tag, " fetch during clear"}, 32'(stray), 32'd0);
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch_chk(input string name, input logic [31:0] pc, input logic [31:0] exp);
      fetch_req = 1'b1;
      PC        = pc;
      tick();
      fetch_req = 1'b0;
      chk1({name, " valid"}, instr_valid, 1'b1);
      chk32({name, " data"}, instruction, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0050_0093, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0010_0113, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h0020_81B3, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_006F, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 32'h0000_0020, 1'b0, 32'h0000_006F, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 32'h0000_0006, 1'b1, NOPW,          1'b1, 1'b0};
      vt[6]  = '{1'b0, 32'h0000_0000, 1'b0, NOPW,          1'b1, 1'b0};
      vt[7]  = '{1'b1, 32'(4*DEPTH),  1'b1, NOPW,          1'b0, 1'b1};
      vt[8]  = '{1'b1, 32'(4*DEPTH+2),1'b1, NOPW,          1'b1, 1'b1};
      vt[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, NOPW,          1'b0, 1'b1};
      vt[10] = '{1'b1, 32'h0000_0010, 1'b1, NOPW,          1'b0, 1'b0};
      vt[11] = '{1'b1, 32'(4*(DEPTH-1)), 1'b1, NOPW,       1'b0, 1'b0};
      vt[12] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0020_81B3, 1'b0, 1'b0};

      rst_n      = 1'b0;
      load_start = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = 32'h0;
      ld_last    = 1'b0;
      fetch_req  = 1'b0;
      PC         = 32'h0;

      // Reset state
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      wait_clear("boot");

      // Program load
      send_word(32'h0050_0093, 1'b0);
      send_word(32'h0010_0113, 1'b0);
      send_word(32'h0020_81B3, 1'b0);
      chk1("mid-load ld_ready", ld_ready, 1'b1);
      send_word(32'h0000_006F, 1'b1);
      chk1("prog load_done", load_done, 1'b1);
      chk1("prog ld_ready", ld_ready, 1'b0);
      chk32("prog load_count", 32'(load_count), 32'd4);

      // Fetch table, back-to-back
      for (int i = 0; i < NV; i++) begin
         fetch_req = vt[i].req;
         PC        = vt[i].pc;
         tick();
         chk1($sformatf("vec%0d valid", i), instr_valid, vt[i].ev);
         chk32($sformatf("vec%0d instr", i), instruction, vt[i].ei);
         chk1($sformatf("vec%0d misaligned", i), fetch_misaligned, vt[i].em);
         chk1($sformatf("vec%0d oob", i), fetch_oob, vt[i].eo);
      end
      fetch_req = 1'b0;
      tick();

      // load_start collides with a fetch: load wins
      load_start = 1'b1;
      fetch_req  = 1'b1;
      PC         = 32'h0;
      tick();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      chk1("collide instr_valid", instr_valid, 1'b0);
      chk1("collide ld_ready", ld_ready, 1'b1);
      chk32("collide load_count", 32'(load_count), 32'd0);
      send_word(32'h1111_1111, 1'b1);
      chk32("reload load_count", 32'(load_count), 32'd1);
      fetch_chk("reload word0", 32'h0, 32'h1111_1111);
      fetch_chk("reload word1 kept", 32'h4, 32'h0010_0113);

      // Overflow: fill the array, offer one extra without last, then a last beat
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
      chk32("full load_count", 32'(load_count), 32'(DEPTH));
      chk1("full no overflow yet", load_overflow, 1'b0);
      send_word(32'hBBBB_0000, 1'b0);
      chk1("extra overflow", load_overflow, 1'b1);
      chk1("extra still ready", ld_ready, 1'b1);
      chk1("extra not done", load_done, 1'b0);
      send_word(32'hCCCC_0000, 1'b1);
      chk1("last-beat done", load_done, 1'b1);
      chk32("ovf load_count", 32'(load_count), 32'(DEPTH));
      fetch_chk("ovf top word", 32'(4*(DEPTH-1)), 32'hA000_0000 + 32'(DEPTH-1));
      fetch_chk("ovf word0", 32'h0, 32'hA000_0000);

      // Overflow is sticky across a new load
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_word(32'h5555_5555, 1'b1);
      chk1("ovf sticky", load_overflow, 1'b1);

      // Asynchronous reset in the middle of a load
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_word(32'h3333_3333, 1'b0);
      send_word(32'h4444_4444, 1'b0);
      chk32("pre-reset load_count", 32'(load_count), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("async");
      tick();
      rst_n = 1'b1;
      wait_clear("reclear");
      send_word(32'h2222_2222, 1'b1);
      fetch_chk("post-reset word0", 32'h0, 32'h2222_2222);
      fetch_chk("post-reset word1 cleared", 32'h4, NOPW);
      fetch_chk("post-reset top cleared", 32'(4*(DEPTH-1)), NOPW);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
